serial_demux_ctrl: RTL and testbench
====================================

Name: serial_demux_ctrl

Overview:
- Parametrised serial-frame receiver and demultiplexer: next generation of the single-line serial-input controller.
- Detects a start bit on one serial line, then shifts in a channel address and a length field.
- Routes the following data bits to one of NUM_CH serial output channels, with a per-channel valid.
- Integrates the counters and shift registers that the earlier controller drove externally; sits between the serial input pin and the per-channel consumers.

Parameters:
- PORT_BITS, 2, width of address field; NUM_CH = 2**PORT_BITS output channels.
- LEN_BITS, 4, width of length field; max payload 2**LEN_BITS-1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clkEn  input  1  advance enable; when 0, all state/registers hold and SerOutValid is 0.
- SerIn  input  1  serial input line; idle high.
- SerOut  output  NUM_CH  per-channel serial data; bit [port] = SerIn while in DATA, all other bits 0.
- SerOutValid  output  NUM_CH  one-hot; bit [port] = 1 in DATA when clkEn=1, else all 0.
- PortId  output  PORT_BITS  latched address of current/last frame.
- Len  output  LEN_BITS  latched length of current/last frame.
- Done  output  1  1 in IDLE (ready for a new frame), 0 otherwise.

Behaviour:
- Reset (async, any state): state=IDLE, port/len shift regs=0, bit counter=0, data counter=0. Outputs: Done=1, SerOutValid=0, SerOut=0, PortId=0, Len=0.
- All sampling and transitions occur on posedge clk only when clkEn=1. clkEn=0 freezes state, counters and shift registers.
- States: IDLE, PORT, LEN, DATA (2-bit encoding; unused codes -> IDLE).
- IDLE:
  - SerIn=0 sampled -> PORT, bit counter cleared.
  - SerIn=1 -> stay.
- PORT:
  - Each enabled cycle shifts SerIn into port reg MSB-first: port <= {port[PORT_BITS-2:0],SerIn}.
  - After PORT_BITS-th bit -> LEN; PortId updates with the complete value on that edge.
- LEN:
  - Shifts LEN_BITS bits MSB-first; Len updates on the last-bit edge.
  - On that edge: full length value == 0 -> IDLE (empty frame, no valid pulses).
  - Otherwise -> DATA, data counter loaded with length value.
- DATA:
  - Outputs are combinational from state, clkEn, SerIn and port reg (Moore plus SerIn passthrough, zero latency).
  - Each enabled cycle presents one payload bit on SerOut[port] with SerOutValid[port]=1, and decrements the data counter.
  - Counter == 1 on an enabled cycle -> IDLE. Exactly Len valid pulses per frame.
- Back-to-back frames:
  - IDLE lasts at least one enabled cycle after DATA (SerIn sampled as start bit only in IDLE).
  - A start bit may arrive in that first IDLE cycle.
- SerIn in DATA is payload regardless of value; no stop bit is checked.
- Widths: bit counter is ceil(log2(max(PORT_BITS,LEN_BITS)))+1 bits; data counter is LEN_BITS bits, never wraps (exits at 1).
- Reset mid-frame aborts immediately; no partial valid afterwards.
- PORT_BITS=1: NUM_CH=2 and one address bit.

Test Plan:
- Reset then idle: rst pulse, SerIn=1, clkEn=1 for 10 cycles -> Done=1, SerOutValid=0, SerOut=0, PortId=0, Len=0 throughout.
- Basic frame (PORT_BITS=2, LEN_BITS=4):
  - Stimulus: SerIn = 0 | 1,0 | 0,0,1,1 | 1,0,1.
  - Response: PortId=2, Len=3; SerOutValid=4'b0100 for exactly 3 cycles; SerOut[2]=1,0,1; other SerOut bits 0; Done=1 on following cycle.
- Zero length: start, port 01, len 0000 -> no SerOutValid pulse, Done=1 on cycle after last len bit, PortId=1, Len=0.
- clkEn gating: basic frame with clkEn=0 on alternate cycles (SerIn held during gaps) -> identical PortId/Len/payload; SerOutValid=0 during every clkEn=0 cycle; 3 valid pulses total.
- Back-to-back and max length:
  - Frame: port 11, len 1111, 15 data bits; start bit in first IDLE cycle, then frame: port 00, len 0001, data 0.
  - Response: 15 pulses on bit 3, then 1 pulse on bit 0 with SerOut[0]=0.
- Reset mid-DATA: assert rst after 2 of 5 payload bits -> outputs immediately Done=1, SerOutValid=0, PortId=0, Len=0; next valid frame after rst release decodes correctly.

Source files
------------

// File: rtl/serial_demux_ctrl.sv
// serial_demux_ctrl: serial frame receiver and demultiplexer.
// Frame layout on SerIn (idle high): start bit (0), PORT_BITS address bits,
// LEN_BITS length bits (both MSB-first), then Len payload bits. Payload bits
// are passed straight through to SerOut[port] with a one-hot valid.
module serial_demux_ctrl #(
  parameter  int PORT_BITS = 2,
  parameter  int LEN_BITS  = 4,
  localparam int NUM_CH    = 2 ** PORT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  input  logic                 SerIn,
  output logic [NUM_CH-1:0]    SerOut,
  output logic [NUM_CH-1:0]    SerOutValid,
  output logic [PORT_BITS-1:0] PortId,
  output logic [LEN_BITS-1:0]  Len,
  output logic                 Done
);

  // Bit counter is sized to count through the longer of the two header fields.
  localparam int MAX_HDR = (PORT_BITS > LEN_BITS) ? PORT_BITS : LEN_BITS;
  localparam int CNT_W   = $clog2(MAX_HDR) + 1;
  localparam logic [CNT_W-1:0] PORT_LAST = CNT_W'(PORT_BITS - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PORT = 2'd1,
    ST_LEN  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t               state_r;
  logic [PORT_BITS-1:0] port_r;
  logic [LEN_BITS-1:0]  len_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [LEN_BITS-1:0]  data_cnt_r;
  logic [PORT_BITS-1:0] port_id_r;
  logic [LEN_BITS-1:0]  len_id_r;

  // Shift candidates: concatenating before truncation keeps PORT_BITS=1 legal.
  logic [PORT_BITS:0]   port_cat_s;
  logic [LEN_BITS:0]    len_cat_s;
  logic [PORT_BITS-1:0] port_next_s;
  logic [LEN_BITS-1:0]  len_next_s;
  logic [NUM_CH-1:0]    ser_out_s;
  logic [NUM_CH-1:0]    valid_s;

  assign port_cat_s  = {port_r, SerIn};
  assign len_cat_s   = {len_r, SerIn};
  assign port_next_s = port_cat_s[PORT_BITS-1:0];
  assign len_next_s  = len_cat_s[LEN_BITS-1:0];

  // Frame sequencer: header shifting, latching of PortId/Len, payload counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      port_r     <= '0;
      len_r      <= '0;
      bit_cnt_r  <= '0;
      data_cnt_r <= '0;
      port_id_r  <= '0;
      len_id_r   <= '0;
    end else if (clkEn) begin
      case (state_r)
        ST_IDLE: begin
          if (SerIn == 1'b0) begin
            state_r   <= ST_PORT;
            bit_cnt_r <= '0;
          end
        end
        ST_PORT: begin
          port_r <= port_next_s;
          if (bit_cnt_r == PORT_LAST) begin
            state_r   <= ST_LEN;
            port_id_r <= port_next_s;
            bit_cnt_r <= '0;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end
        ST_LEN: begin
          len_r <= len_next_s;
          if (bit_cnt_r == LEN_LAST) begin
            len_id_r  <= len_next_s;
            bit_cnt_r <= '0;
            if (len_next_s == '0) begin
              // Empty frame: no payload, straight back to idle.
              state_r <= ST_IDLE;
            end else begin
              state_r    <= ST_DATA;
              data_cnt_r <= len_next_s;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          // Leave on the last payload bit so the counter never wraps.
          data_cnt_r <= data_cnt_r - LEN_BITS'(1);
          if (data_cnt_r == LEN_BITS'(1)) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Payload passthrough: zero-latency routing of SerIn to the addressed channel.
  always_comb begin
    ser_out_s = '0;
    valid_s   = '0;
    if (state_r == ST_DATA) begin
      ser_out_s[port_r] = SerIn;
      valid_s[port_r]   = clkEn;
    end else begin
      ser_out_s = '0;
      valid_s   = '0;
    end
  end

  assign SerOut      = ser_out_s;
  assign SerOutValid = valid_s;
  assign PortId      = port_id_r;
  assign Len         = len_id_r;
  assign Done        = (state_r == ST_IDLE);

endmodule

// File: tb/tb_serial_demux_ctrl.sv
// Self-checking bench for serial_demux_ctrl (PORT_BITS=2, LEN_BITS=4).
// Expected outputs come from the frame layout the bench itself transmits:
// start bit in idle, header bits busy with no valid, payload bits routed to
// the addressed channel, idle afterwards.
module tb_serial_demux_ctrl;

  logic       clk;
  logic       rst;
  logic       clkEn;
  logic       SerIn;
  logic [3:0] SerOut;
  logic [3:0] SerOutValid;
  logic [1:0] PortId;
  logic [3:0] Len;
  logic       Done;

  int tests;
  int fails;

  serial_demux_ctrl #(.PORT_BITS(2), .LEN_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .clkEn       (clkEn),
    .SerIn       (SerIn),
    .SerOut      (SerOut),
    .SerOutValid (SerOutValid),
    .PortId      (PortId),
    .Len         (Len),
    .Done        (Done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare the per-cycle outputs against expectations.
  task automatic check_outs(input logic [3:0] ev, input logic [3:0] eo,
                            input logic ed, input string tag);
    tests++;
    assert (SerOutValid === ev) else begin
      fails++;
      $error("FAIL %s valid: got %b expected %b", tag, SerOutValid, ev);
    end
    tests++;
    assert (SerOut === eo) else begin
      fails++;
      $error("FAIL %s serout: got %b expected %b", tag, SerOut, eo);
    end
    tests++;
    assert (Done === ed) else begin
      fails++;
      $error("FAIL %s done: got %b expected %b", tag, Done, ed);
    end
  endtask

  task automatic check_ids(input logic [1:0] ep, input logic [3:0] el, input string tag);
    tests++;
    assert (PortId === ep) else begin
      fails++;
      $error("FAIL %s portid: got %0d expected %0d", tag, PortId, ep);
    end
    tests++;
    assert (Len === el) else begin
      fails++;
      $error("FAIL %s len: got %0d expected %0d", tag, Len, el);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, let the edge sample.
  task automatic step(input logic en, input logic ser, input logic [3:0] ev,
                      input logic [3:0] eo, input logic ed, input string tag);
    clkEn = en;
    SerIn = ser;
    @(negedge clk);
    check_outs(ev, eo, ed, tag);
    @(posedge clk);
    #1;
  endtask

  // One serial bit, optionally preceded by a clkEn=0 gap with SerIn held.
  task automatic send_bit(input bit gated, input logic ser, input logic [3:0] ev,
                          input logic [3:0] eo, input logic ed, input string tag);
    if (gated) step(1'b0, ser, 4'b0000, eo, ed, {tag, "_gap"});
    step(1'b1, ser, ev, eo, ed, tag);
  endtask

  // Transmit a frame; only the first nsend payload bits are sent.
  task automatic send_frame(input logic [1:0] p, input logic [3:0] l,
                            input logic [14:0] pay, input int nsend, input bit gated);
    logic [3:0] onehot;
    onehot = 4'b0001 << p;
    send_bit(gated, 1'b0, 4'b0000, 4'b0000, 1'b1, "start");
    for (int i = 1; i >= 0; i--) send_bit(gated, p[i], 4'b0000, 4'b0000, 1'b0, "port");
    for (int i = 3; i >= 0; i--) send_bit(gated, l[i], 4'b0000, 4'b0000, 1'b0, "len");
    for (int i = 0; i < nsend; i++)
      send_bit(gated, pay[i], onehot, pay[i] ? onehot : 4'b0000, 1'b0, "data");
  endtask

  task automatic idle_step(input string tag);
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, tag);
  endtask

  initial begin
    logic [1:0]  rp;
    logic [3:0]  rl;
    logic [14:0] rpay;
    bit          rg;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    clkEn = 1'b1;
    SerIn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs(4'b0000, 4'b0000, 1'b1, "in_reset");
    check_ids(2'd0, 4'd0, "in_reset");
    rst = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      idle_step("reset_idle");
      check_ids(2'd0, 4'd0, "reset_idle");
    end

    // Basic frame: port 2, len 3, payload 1,0,1.
    send_frame(2'd2, 4'd3, 15'b101, 3, 1'b0);
    idle_step("basic_tail");
    check_ids(2'd2, 4'd3, "basic");

    // Zero-length frame: no valid pulses, idle right after the length field.
    send_frame(2'd1, 4'd0, 15'd0, 0, 1'b0);
    idle_step("zero_tail");
    check_ids(2'd1, 4'd0, "zero");

    // Basic frame with clkEn low on alternate cycles.
    send_frame(2'd2, 4'd3, 15'b101, 3, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, "gated_tail_gap");
    idle_step("gated_tail");
    check_ids(2'd2, 4'd3, "gated");

    // Max length frame followed immediately by a one-bit frame.
    rpay = 15'($urandom);
    send_frame(2'd3, 4'd15, rpay, 15, 1'b0);
    check_ids(2'd3, 4'd15, "maxlen");
    send_frame(2'd0, 4'd1, 15'd0, 1, 1'b0);
    idle_step("b2b_tail");
    check_ids(2'd0, 4'd1, "b2b");

    // Reset during payload aborts the frame immediately.
    send_frame(2'd1, 4'd5, 15'($urandom), 2, 1'b0);
    SerIn = 1'b1;
    rst   = 1'b1;
    #1;
    check_outs(4'b0000, 4'b0000, 1'b1, "mid_reset");
    check_ids(2'd0, 4'd0, "mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_step("post_reset");
    rpay = 15'($urandom);
    send_frame(2'd2, 4'd3, rpay, 3, 1'b0);
    idle_step("post_reset_tail");
    check_ids(2'd2, 4'd3, "post_reset");

    // Randomised frames, some gated, some back-to-back.
    for (int n = 0; n < 12; n++) begin
      rp   = 2'($urandom);
      rl   = 4'($urandom);
      rpay = 15'($urandom);
      rg   = 1'($urandom);
      send_frame(rp, rl, rpay, int'(rl), rg);
      if ($urandom_range(0, 1) == 0) begin
        idle_step("rand_tail");
      end
      check_ids(rp, rl, "rand");
    end
    idle_step("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
